seg_display_scanner: RTL

Four-digit multiplexed seven-segment display driver. Sits downstream of the memory-mapped display register (RAM word 1) written by the CPU, and consumes the 16-bit value the CPU stores there. It accepts a value through a level load strobe from the CPU clock domain, double-buffers it, swaps it in only on frame boundaries, and scans the four digits with guard gaps, active-low drive and optional leading-zero blanking.

---
 rtl/display_pkg.sv | 16 +
 rtl/hex7_decoder.sv | 11 +
 rtl/seg_display_scanner.sv | 134 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and types for the seven-segment scanner
package display_pkg;

  // Scan FSM: a dark guard cycle between every pair of lit digits
  typedef enum logic {GUARD = 1'b0, ON = 1'b1} scan_state_t;

  localparam logic [3:0] DIG_OFF = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-high g..a patterns for hex digits 0..F
  localparam logic [6:0] SEG7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7_decoder.sv
// rtl/hex7_decoder.sv - nibble to active-high seven-segment pattern
module hex7_decoder
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG7[i_nibble];

endmodule

// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - double-buffered four-digit multiplexed display scanner
module seg_display_scanner
  import display_pkg::*;
#(
  parameter int SLOT_TICKS = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic        clock1KHz,
  input  logic        RAMclr,
  input  logic [15:0] value,
  input  logic        value_ld,
  output logic [3:0]  dig,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int CNT_W = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SLOT_TICKS - 1);

  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              w_rise;
  logic [15:0]       r_pending;
  logic              r_pend_flag;
  logic [15:0]       r_shown;
  scan_state_t       r_state;
  logic [1:0]        r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_boundary;
  logic              w_last_tick;
  logic [3:0]        w_nibble;
  logic [6:0]        w_pattern;
  logic              w_lz;
  logic              w_blank;
  logic [3:0]        r_dig;
  logic [7:0]        r_seg;
  logic              r_frame_start;

  assign w_rise      = r_s2 & ~r_s3;
  assign w_boundary  = (r_state == GUARD) && (r_idx == 2'd3);
  assign w_last_tick = (r_cnt == LAST_TICK);
  assign w_nibble    = r_shown[{r_idx, 2'b00} +: 4];
  assign w_blank     = (BLANK_LZ != 0) && w_lz;

  hex7_decoder u_hex7_decoder (
    .i_nibble (w_nibble),
    .o_seg    (w_pattern)
  );

  // Two-flop synchronizer on the CPU-domain strobe plus an edge register
  always_ff @(posedge clock1KHz or posedge RAMclr) begin
    if (RAMclr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= value_ld;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Capture on each strobe rise; swap into the shown buffer only at the frame boundary
  always_ff @(posedge clock1KHz or posedge RAMclr) begin
    if (RAMclr) begin
      r_pending   <= 16'h0000;
      r_pend_flag <= 1'b0;
      r_shown     <= 16'h0000;
    end else begin
      if (w_boundary && r_pend_flag) begin
        r_shown <= r_pending;
      end
      // A rise coinciding with the swap refills pending and keeps the flag for next frame
      if (w_rise) begin
        r_pending   <= value;
        r_pend_flag <= 1'b1;
      end else if (w_boundary) begin
        r_pend_flag <= 1'b0;
      end
    end
  end

  // Guard/on scan sequencing over digits 3, 2, 1, 0
  always_ff @(posedge clock1KHz or posedge RAMclr) begin
    if (RAMclr) begin
      r_state <= GUARD;
      r_idx   <= 2'd3;
      r_cnt   <= '0;
    end else if (r_state == GUARD) begin
      r_state <= ON;
      r_cnt   <= '0;
    end else if (w_last_tick) begin
      r_state <= GUARD;
      r_idx   <= r_idx - 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Leading-zero test: everything at and above the current digit is zero
  always_comb begin
    w_lz = 1'b0;
    case (r_idx)
      2'd3:    w_lz = (r_shown[15:12] == 4'h0);
      2'd2:    w_lz = (r_shown[15:8]  == 8'h00);
      2'd1:    w_lz = (r_shown[15:4]  == 12'h000);
      default: w_lz = 1'b0;
    endcase
  end

  // Registered active-low drive; blanked digits keep their slot but stay dark
  always_ff @(posedge clock1KHz or posedge RAMclr) begin
    if (RAMclr) begin
      r_dig         <= DIG_OFF;
      r_seg         <= SEG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      if ((r_state == ON) && !w_blank) begin
        r_dig <= ~(4'b0001 << r_idx);
        r_seg <= {1'b1, ~w_pattern};
      end else begin
        r_dig <= DIG_OFF;
        r_seg <= SEG_OFF;
      end
    end
  end

  assign dig         = r_dig;
  assign seg         = r_seg;
  assign frame_start = r_frame_start;

endmodule
